// File: rtl/bus_arbiter.sv
// bus_arbiter: 4-way round-robin bus arbiter with a one-cycle turnaround gap between grants.
// Optional BUS_TIMEOUT_EN macro adds an 8-bit hold counter that forces release after MAX_HOLD cycles.
`default_nettype none

module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [1:0] cand;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 2..255");
  end

  // Scan from the highest offset down so the requester nearest ptr overwrites the others.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (REQ[cand]) winner = cand;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      GNT   <= 4'b0000;
      OWNER <= 2'd0;
      BUSY  <= 1'b0;
      ptr   <= 2'd0;
`ifdef BUS_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            state <= S_GRANT;
            GNT   <= 4'b0001 << winner;
            OWNER <= winner;
            BUSY  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end

        S_GRANT: begin
          if (!REQ[OWNER]) begin
            state <= S_RELEASE;
            GNT   <= 4'b0000;
            OWNER <= 2'd0;
            BUSY  <= 1'b0;
            ptr   <= OWNER + 2'd1;
`ifdef BUS_TIMEOUT_EN
          end else if (hold_cnt == HOLD_LAST) begin
            // Owner has held the bus for MAX_HOLD cycles: force it off and demote it.
            state     <= S_RELEASE;
            GNT       <= 4'b0000;
            OWNER     <= 2'd0;
            BUSY      <= 1'b0;
            ptr       <= OWNER + 2'd1;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end

        S_RELEASE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          GNT   <= 4'b0000;
          OWNER <= 2'd0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum grant length in cycles when BUS_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RST  input  1  reset; asynchronous and active-low (RST=0 resets).
REQ-004 Port: REQ  input  4  per-requester bus request; REQ[i] is register/core i.
REQ-005 Port: GNT  output  4  one-hot bus grant; drives LDBUS of the owning register.
REQ-006 Port: OWNER  output  2  index of current grantee; valid only while BUSY=1, else 0.
REQ-007 Port: BUSY  output  1  high while any GNT bit is high.
REQ-008 Port: TIMEOUT  output  1  one-cycle pulse on forced release; tied 0 without BUS_TIMEOUT_EN.

Function
REQ-009 Arbiter SHALL have three states: IDLE, GRANT, RELEASE; all outputs registered.
REQ-010 IDLE: no REQ bit high -> stay IDLE; any REQ bit high -> next edge enter GRANT with GNT = round-robin winner.
REQ-011 Winner SHALL be the first requester with REQ high, searching from pointer PTR upward modulo 4 (PTR, PTR+1, ..., PTR+3).
REQ-012 Grant latency SHALL be exactly 1 cycle: REQ sampled high in IDLE -> GNT high after the next rising edge.
REQ-013 GNT SHALL be one-hot or all-zero at every cycle; two bits never high together.
REQ-014 GRANT: GNT held constant while REQ[OWNER]=1; other requests are ignored, no preemption.
REQ-015 GRANT: REQ[OWNER] sampled 0 -> next edge enter RELEASE, GNT=0, BUSY=0, PTR=(OWNER+1) mod 4.
REQ-016 RELEASE SHALL last exactly one cycle with GNT=0 (bus turnaround, no overlapping tristate drivers), then IDLE.
REQ-017 Minimum gap between consecutive grants SHALL be 2 cycles with GNT=0 (RELEASE, IDLE).
REQ-018 A requester SHALL NOT be granted while its REQ is 0; REQ pulses shorter than one sampled edge are ignored.
REQ-019 PTR SHALL wrap from 3 to 0.
REQ-020 Simultaneous REQ rise of several requesters in IDLE -> only the REQ-011 winner is granted; others stay pending.

Reset
REQ-021 RST=0 SHALL immediately force state IDLE, GNT=4'b0000, OWNER=0, BUSY=0, TIMEOUT=0, PTR=0, hold counter=0, regardless of clk.
REQ-022 Reset asserted during GRANT SHALL drop GNT asynchronously; no RELEASE cycle follows.
REQ-023 After RST returns to 1, first arbitration SHALL occur on the first rising edge with REQ high.

Configuration
REQ-024 Macro BUS_TIMEOUT_EN SHALL compile in an 8-bit hold counter and forced release.
REQ-025 With BUS_TIMEOUT_EN: counter cleared on grant, increments each GRANT cycle; at MAX_HOLD grant cycles with REQ[OWNER] still 1 -> next edge RELEASE, TIMEOUT=1 for that one cycle, PTR=(OWNER+1) mod 4.
REQ-026 With BUS_TIMEOUT_EN, a timed-out requester still holding REQ SHALL be re-arbitrated normally (lowest priority) after RELEASE.
REQ-027 Without BUS_TIMEOUT_EN: no counter, grant held indefinitely while REQ[OWNER]=1, TIMEOUT constant 0.

Verification
REQ-028 Reset: RST=0 while REQ=4'b1111 -> GNT=0, BUSY=0, OWNER=0, TIMEOUT=0 with no clock edge needed.
REQ-029 Single request: REQ=4'b0100 from IDLE -> GNT=4'b0100, OWNER=2 after 1 edge; REQ drop -> GNT=0 next edge, RELEASE 1 cycle.
REQ-030 Round-robin: REQ=4'b1111 held, each owner drops REQ after 3 grant cycles then re-raises -> grant order 0,1,2,3,0 with 2 idle cycles between grants.
REQ-031 Wrap/priority: PTR=3 (after owner 2 released), REQ=4'b1001 -> GNT=4'b1000 first, then 4'b0001.
REQ-032 Timeout (BUS_TIMEOUT_EN, MAX_HOLD=4): REQ=4'b0011 held -> GNT=0001 for 4 cycles, TIMEOUT pulse, RELEASE, then GNT=0010.
REQ-033 Mid-grant reset: GNT=4'b0010, RST pulsed low mid-cycle -> GNT=0 immediately; after release REQ=4'b0010 -> regranted from PTR=0 search.
